jtcps1_obj_dma: RTL and testbench
=================================

JTCPS1_OBJ_DMA -- requirements
Module: jtcps1_obj_dma

Interface
REQ-001 SHALL have parameter: TW, 10, log2 of object-table depth in 16-bit words.
REQ-002 SHALL have port: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: frame_start  in  1  one-cycle pulse at vblank, requests a table copy.
REQ-005 SHALL have port: obj_base  in  10  object table base in VRAM, units of 128 words.
REQ-006 SHALL have port: vram_addr  out  17  VRAM word address.
REQ-007 SHALL have port: vram_cs  out  1  VRAM read request.
REQ-008 SHALL have port: vram_data  in  16  VRAM read data.
REQ-009 SHALL have port: vram_ok  in  1  read acknowledge, data valid this cycle.
REQ-010 SHALL have port: frame_addr  in  TW  object line-table read address.
REQ-011 SHALL have port: frame_data  out  16  object table word at frame_addr.
REQ-012 SHALL have port: frame_ok  out  1  frame_data valid for current frame_addr.
REQ-013 SHALL have port: busy  out  1  copy in progress.

Function
REQ-014 SHALL hold two banks of 2^TW x 16 RAM; reader side uses front bank, copy writes back bank; bank_sel selects front.
REQ-015 SHALL implement states IDLE, REQ, SWAP.
REQ-016 IDLE: on frame_start, latch obj_base into base_l, clear idx to 0, go REQ; busy=1 from next cycle.
REQ-017 REQ: vram_cs=1, vram_addr = ({base_l,7'b0} + idx) mod 2^17, both stable until vram_ok.
REQ-018 vram_ok SHALL be ignored when vram_cs=0.
REQ-019 REQ with vram_ok=1: write vram_data to back bank at idx in that cycle; vram_cs drops next cycle for exactly one cycle before the next request.
REQ-020 End of copy after the write when idx[1:0]==3 and vram_data[15:8]==8'hFF (end marker, stored as is) or idx==2^TW-1; else idx+1, stay REQ.
REQ-021 SWAP: one cycle; toggle bank_sel, set valid=1, busy=0 next cycle, go IDLE.
REQ-022 Back-bank words past the end marker SHALL keep stale contents; never cleared.
REQ-023 frame_start while busy or in SWAP SHALL be ignored, not queued.
REQ-024 Read path: frame_data registered from front bank at frame_addr, 1-cycle latency.
REQ-025 frame_ok = valid AND (registered address == current frame_addr); low the cycle after any frame_addr change.
REQ-026 Bank swap SHALL take effect on frame_data in the cycle after SWAP; frame_ok SHALL drop for that one cycle.
REQ-027 A TW-bit idx SHALL never wrap; the last index terminates the copy.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, vram_cs=0, busy=0, valid=0, frame_ok=0, bank_sel=0, idx=0, base_l=0, vram_addr=0, frame_data=0.
REQ-029 Reset mid-copy SHALL abort the copy with no swap; RAM contents are undefined after reset.
REQ-030 After release, first frame_ok=1 only after one completed copy.

Verification
REQ-031 Reset, obj_base=10'h3C, frame_start pulse, VRAM model acks after 2 cycles, marker 16'hFF00 at idx 7 -> addresses 17'h1E00..17'h1E07, SWAP, busy low; frame_addr=7 -> frame_data=16'hFF00, frame_ok=1 one cycle later.
REQ-032 No marker in table, TW=10 -> exactly 1024 requests, last vram_addr = base+1023, then swap.
REQ-033 Second copy running; reader sweeps frame_addr -> data from old front bank until SWAP, new data from the cycle after, frame_ok low one cycle at swap.
REQ-034 frame_start pulses at idx 3 and in the SWAP cycle -> ignored, single copy, single swap, no new request.
REQ-035 rst_n low for one cycle while vram_cs=1 at idx 5 -> vram_cs=0 at once, valid=0, frame_ok=0, no swap; next frame_start restarts at idx 0.
REQ-036 obj_base=10'h3FF -> vram_addr wraps mod 2^17 from 17'h1FF80 to 17'h00000 at idx 128.

Source files
------------

// File: rtl/jtcps1_obj_dma_if.sv
// VRAM read bus between the object-table DMA and the VRAM arbiter.
//   vram_addr : word address of the current read request
//   vram_cs   : read request, held with a stable address until acknowledged
//   vram_data : read data, valid in the cycle vram_ok is high
//   vram_ok   : read acknowledge; only meaningful while vram_cs is high
// master = DMA side (issues requests), slave = VRAM side (answers them).
interface jtcps1_obj_dma_if;
    logic [16:0] vram_addr;
    logic        vram_cs;
    logic [15:0] vram_data;
    logic        vram_ok;

    modport master (output vram_addr, output vram_cs, input vram_data, input vram_ok);
    modport slave  (input vram_addr, input vram_cs, output vram_data, output vram_ok);
endinterface

// File: rtl/jtcps1_obj_dma.sv
// Object table DMA: at each vblank (frame_start) copies the object table
// from VRAM into the back half of a double-buffered RAM, then swaps halves
// so the object line engine always reads a complete, stable table.
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   frame_start : one-cycle pulse requesting a table copy
//   obj_base    : table base in VRAM, units of 128 words
//   vram        : VRAM read bus (master side)
//   frame_addr  : read address into the front table
//   frame_data  : front-table word at frame_addr, one cycle of latency
//   frame_ok    : frame_data is valid and belongs to the current frame_addr
//   busy        : a copy (including the swap cycle) is in progress
module jtcps1_obj_dma #(
    parameter int TW = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [9:0]            obj_base,
    jtcps1_obj_dma_if.master      vram,
    input  logic [TW-1:0]         frame_addr,
    output logic [15:0]           frame_data,
    output logic                  frame_ok,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, REQ, SWAP} state_t;

    localparam logic [TW-1:0] IDX_ONE  = TW'(1);
    localparam logic [TW-1:0] IDX_LAST = '1;

    state_t          state_reg, state_next;
    logic [TW-1:0]   idx_reg, idx_next;
    logic [9:0]      base_l_reg, base_l_next;
    logic            gap_reg, gap_next;       // forces one idle cycle between requests
    logic            bank_sel_reg, bank_sel_next;
    logic            valid_reg, valid_next;
    logic            swap_d_reg;              // high the cycle after SWAP
    logic [TW-1:0]   addr_reg;
    logic [15:0]     frame_data_reg;

    logic            ack;
    logic            last_word;
    logic            rd_bank;

    // Both banks live in one array; the top address bit picks the bank.
    logic [15:0]     mem [0:2**(TW+1)-1];

    // A request is acknowledged only while it is actually on the bus.
    assign ack = (state_reg == REQ) && !gap_reg && vram.vram_ok;

    // End marker lives in the last word of a 4-word object entry; the final
    // index also ends the copy so idx never wraps.
    assign last_word = ((idx_reg[1:0] == 2'd3) && (vram.vram_data[15:8] == 8'hFF))
                       || (idx_reg == IDX_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            base_l_reg   <= '0;
            gap_reg      <= 1'b0;
            bank_sel_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            base_l_reg   <= base_l_next;
            gap_reg      <= gap_next;
            bank_sel_reg <= bank_sel_next;
            valid_reg    <= valid_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        base_l_next   = base_l_reg;
        gap_next      = gap_reg;
        bank_sel_next = bank_sel_reg;
        valid_next    = valid_reg;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    base_l_next = obj_base;
                    idx_next    = '0;
                    gap_next    = 1'b0;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (gap_reg) begin
                    gap_next = 1'b0;
                end else if (vram.vram_ok) begin
                    if (last_word) begin
                        state_next = SWAP;
                    end else begin
                        idx_next = idx_reg + IDX_ONE;
                        gap_next = 1'b1;
                    end
                end
            end
            SWAP: begin
                bank_sel_next = ~bank_sel_reg;
                valid_next    = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        vram.vram_cs   = (state_reg == REQ) && !gap_reg;
        vram.vram_addr = {base_l_reg, 7'b0} + 17'(idx_reg);
        busy           = (state_reg != IDLE);
    end

    // Copy writes always target the back bank.
    always_ff @(posedge clk) begin
        if (ack) begin
            mem[{~bank_sel_reg, idx_reg}] <= vram.vram_data;
        end
    end

    // During SWAP the read already uses the new front bank so fresh data
    // appears on frame_data in the cycle right after SWAP.
    assign rd_bank = bank_sel_reg ^ (state_reg == SWAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data_reg <= '0;
            addr_reg       <= '0;
            swap_d_reg     <= 1'b0;
        end else begin
            frame_data_reg <= mem[{rd_bank, frame_addr}];
            addr_reg       <= frame_addr;
            swap_d_reg     <= (state_reg == SWAP);
        end
    end

    assign frame_data = frame_data_reg;
    // Suppressed for the one cycle after a swap so a reader notices the change.
    assign frame_ok   = valid_reg && (addr_reg == frame_addr) && !swap_d_reg;
endmodule

// File: tb/tb_jtcps1_obj_dma.sv
module tb_jtcps1_obj_dma;
    localparam int TW    = 10;
    localparam int DEPTH = 1 << TW;
    localparam int VSIZE = 131072;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [9:0]    obj_base = '0;
    logic [TW-1:0] frame_addr = '0;
    logic [15:0]   frame_data;
    logic          frame_ok;
    logic          busy;

    jtcps1_obj_dma_if bus ();

    jtcps1_obj_dma #(.TW(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .obj_base    (obj_base),
        .vram        (bus),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data),
        .frame_ok    (frame_ok),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- VRAM model ----------------
    logic [15:0] vmem [0:VSIZE-1];
    logic [16:0] ack_q [$];
    int          lat = 2;
    int          wcnt = 0;

    // Answers a request after lat waiting cycles. With no request it throws
    // random acknowledges and data at the bus, which must be ignored.
    always @(negedge clk) begin
        if (rst_n && bus.vram_cs) begin
            if (wcnt >= lat) begin
                bus.vram_ok   = 1'b1;
                bus.vram_data = vmem[bus.vram_addr];
                ack_q.push_back(bus.vram_addr);
                wcnt = 0;
            end else begin
                bus.vram_ok   = 1'b0;
                bus.vram_data = 16'($urandom);
                wcnt++;
            end
        end else begin
            bus.vram_ok   = ($urandom_range(0, 3) == 0);
            bus.vram_data = 16'($urandom) | 16'hFF00;
            wcnt = 0;
        end
    end

    // ---------------- reference model ----------------
    int          exp_len;
    logic [16:0] exp_addr [DEPTH];
    logic [15:0] exp_tab  [DEPTH];
    logic [15:0] mbank    [2][DEPTH];
    bit          mknown   [2][DEPTH];
    int          mfront;
    bit          mvalid;

    // The table a copy from this base should fetch, in order.
    function automatic void model_plan(input int base);
        exp_len = 0;
        for (int i = 0; i < DEPTH; i++) begin
            int a = (base * 128 + i) % VSIZE;
            exp_addr[i] = 17'(a);
            exp_tab[i]  = vmem[a];
            exp_len     = i + 1;
            if ((i % 4 == 3 && vmem[a][15:8] == 8'hFF) || i == DEPTH - 1) break;
        end
    endfunction

    function automatic void model_reset();
        mfront = 0;
        mvalid = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) mknown[b][i] = 0;
    endfunction

    // Removes accidental end markers from a table; mark >= 0 places one.
    function automatic void scrub(input int base, input int mark, input logic [15:0] mval);
        for (int i = 0; i < DEPTH; i++) begin
            int a = (base * 128 + i) % VSIZE;
            if (i % 4 == 3 && vmem[a][15:8] == 8'hFF) vmem[a][15:8] = 8'hFE;
        end
        if (mark >= 0) vmem[(base * 128 + mark) % VSIZE] = mval;
    endfunction

    // ---------------- tasks ----------------
    task automatic do_copy(input int base, input int latency, input string name);
        int cyc;
        int bad;
        int n;
        int back;
        lat = latency;
        obj_base = 10'(base);
        model_plan(base);
        ack_q.delete();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_rise: busy=%b required 1", name, busy);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: busy=%b required 0 after %0d cycles", name, busy, cyc);
        end
        checks++;
        if (frame_ok !== 1'b0) begin
            failures++;
            $display("FAIL %s_swap_ok_drop: frame_ok=%b required 0", name, frame_ok);
        end
        checks++;
        if (ack_q.size() != exp_len) begin
            failures++;
            $display("FAIL %s_req_count: requests=%0d required %0d", name, ack_q.size(), exp_len);
        end
        n = (ack_q.size() < exp_len) ? ack_q.size() : exp_len;
        bad = -1;
        for (int i = 0; i < n; i++) begin
            if (ack_q[i] !== exp_addr[i]) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s_req_addr: idx %0d vram_addr=%05h required %05h",
                     name, bad, ack_q[bad], exp_addr[bad]);
        end
        back = 1 - mfront;
        for (int i = 0; i < exp_len; i++) begin
            mbank[back][i]  = exp_tab[i];
            mknown[back][i] = 1;
        end
        mfront = back;
        mvalid = 1;
        $display("copy %s: base=%03h latency=%0d requests=%0d expected=%0d",
                 name, base, latency, ack_q.size(), exp_len);
    endtask

    task automatic read_check(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            logic [TW-1:0] a;
            a = TW'($urandom_range(0, DEPTH - 1));
            frame_addr = a;
            @(posedge clk); #1;
            if (mvalid && mknown[mfront][a]) begin
                checks++;
                if (frame_data !== mbank[mfront][a]) begin
                    failures++;
                    $display("FAIL %s_data: addr %03h frame_data=%04h required %04h",
                             name, a, frame_data, mbank[mfront][a]);
                end
            end
            checks++;
            if (frame_ok !== mvalid) begin
                failures++;
                $display("FAIL %s_ok: addr %03h frame_ok=%b required %b", name, a, frame_ok, mvalid);
            end
        end
        $display("reads %s: %0d random addresses", name, n);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.vram_cs !== 1'b0 || busy !== 1'b0 || frame_ok !== 1'b0 ||
            bus.vram_addr !== 17'h0 || frame_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: cs=%b busy=%b ok=%b addr=%05h data=%04h required all 0",
                     bus.vram_cs, busy, frame_ok, bus.vram_addr, frame_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (frame_ok !== 1'b0 || ack_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: ok=%b requests=%0d busy=%b required 0/0/0",
                     frame_ok, ack_q.size(), busy);
        end
        $display("reset: checked");
    endtask

    task automatic test_basic();
        scrub(10'h3C, 7, 16'hFF00);
        do_copy(10'h3C, 2, "basic");
        checks++;
        if (ack_q.size() != 8 || ack_q[0] !== 17'h1E00 || ack_q[ack_q.size() - 1] !== 17'h1E07) begin
            failures++;
            $display("FAIL basic_range: requests=%0d first=%05h last=%05h required 8 1e00 1e07",
                     ack_q.size(), ack_q[0], ack_q[ack_q.size() - 1]);
        end
        frame_addr = TW'(7);
        @(posedge clk); #1;
        checks++;
        if (frame_data !== 16'hFF00 || frame_ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_read7: data=%04h ok=%b required ff00 1", frame_data, frame_ok);
        end
        read_check(16, "basic");
    endtask

    task automatic test_no_marker();
        int base;
        int last;
        base = $urandom_range(0, 1023);
        scrub(base, -1, 16'h0);
        do_copy(base, $urandom_range(0, 1), "no_marker");
        last = (base * 128 + 1023) % VSIZE;
        checks++;
        if (ack_q.size() != 1024 || ack_q[ack_q.size() - 1] !== 17'(last)) begin
            failures++;
            $display("FAIL no_marker_last: requests=%0d last=%05h required 1024 %05h",
                     ack_q.size(), ack_q[ack_q.size() - 1], last);
        end
        read_check(24, "no_marker");
    endtask

    task automatic test_swap_read();
        int base;
        int mark;
        int a;
        logic [15:0] old_v;
        logic [15:0] new_v;
        base  = $urandom_range(0, 1023);
        mark  = 4 * $urandom_range(1, 100) + 3;
        scrub(base, mark, 16'hFF00 | 16'($urandom_range(0, 255)));
        a     = $urandom_range(0, mark);
        old_v = mbank[mfront][a];
        new_v = vmem[(base * 128 + a) % VSIZE];
        frame_addr = TW'(a);
        repeat (2) begin
            @(posedge clk); #1;
        end
        fork
            do_copy(base, $urandom_range(0, 3), "swap");
            begin
                int cyc;
                int bad;
                cyc = 0;
                bad = 0;
                while (busy !== 1'b1 && cyc < 10) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                while (busy === 1'b1 && cyc < 20000) begin
                    if (frame_data !== old_v || frame_ok !== 1'b1) bad++;
                    @(posedge clk); #1;
                    cyc++;
                end
                checks++;
                if (bad != 0) begin
                    failures++;
                    $display("FAIL swap_old_front: %0d cycles differed, required data=%04h ok=1", bad, old_v);
                end
                checks++;
                if (frame_data !== new_v || frame_ok !== 1'b0) begin
                    failures++;
                    $display("FAIL swap_edge: data=%04h ok=%b required %04h 0", frame_data, frame_ok, new_v);
                end
                @(posedge clk); #1;
                checks++;
                if (frame_data !== new_v || frame_ok !== 1'b1) begin
                    failures++;
                    $display("FAIL swap_after: data=%04h ok=%b required %04h 1", frame_data, frame_ok, new_v);
                end
            end
        join
        read_check(16, "swap");
    endtask

    task automatic test_ignore();
        int base;
        base = $urandom_range(0, 1023);
        scrub(base, 11, 16'hFFA5);
        fork
            do_copy(base, 1, "ignore");
            begin
                int cyc;
                cyc = 0;
                while (ack_q.size() < 3 && cyc < 5000) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                frame_start = 1'b1;
                @(posedge clk); #1 frame_start = 1'b0;
                while (ack_q.size() < 12 && cyc < 5000) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                frame_start = 1'b1;
                @(posedge clk); #1 frame_start = 1'b0;
            end
        join
        repeat (20) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ack_q.size() != 12 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_restart: requests=%0d busy=%b required 12 0", ack_q.size(), busy);
        end
        read_check(16, "ignore");
    endtask

    task automatic test_reset_mid();
        int base;
        int cyc;
        base = $urandom_range(0, 1023);
        scrub(base, 15, 16'hFF11);
        lat = 4;
        obj_base = 10'(base);
        ack_q.delete();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        cyc = 0;
        while (!(ack_q.size() == 5 && bus.vram_cs === 1'b1) && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (ack_q.size() != 5 || bus.vram_cs !== 1'b1) begin
            failures++;
            $display("FAIL midreset_setup: requests=%0d cs=%b required 5 1", ack_q.size(), bus.vram_cs);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.vram_cs !== 1'b0 || busy !== 1'b0 || frame_ok !== 1'b0 ||
            bus.vram_addr !== 17'h0 || frame_data !== 16'h0) begin
            failures++;
            $display("FAIL midreset_outputs: cs=%b busy=%b ok=%b addr=%05h data=%04h required all 0",
                     bus.vram_cs, busy, frame_ok, bus.vram_addr, frame_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        repeat (10) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ack_q.size() != 5 || frame_ok !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abort: requests=%0d ok=%b busy=%b required 5 0 0",
                     ack_q.size(), frame_ok, busy);
        end
        do_copy(base, $urandom_range(0, 2), "restart");
        checks++;
        if (ack_q.size() == 0 || ack_q[0] !== 17'((base * 128) % VSIZE)) begin
            failures++;
            $display("FAIL restart_idx0: first=%05h required %05h", ack_q[0], 17'((base * 128) % VSIZE));
        end
        read_check(16, "restart");
    endtask

    task automatic test_wrap();
        scrub(10'h3FF, 131, 16'hFF42);
        do_copy(10'h3FF, $urandom_range(0, 2), "wrap");
        checks++;
        if (ack_q.size() != 132 || ack_q[127] !== 17'h1FFFF || ack_q[128] !== 17'h00000) begin
            failures++;
            $display("FAIL wrap_addr: requests=%0d idx127=%05h idx128=%05h required 132 1ffff 00000",
                     ack_q.size(), ack_q[127], ack_q[128]);
        end
        read_check(16, "wrap");
    endtask

    initial begin
        for (int i = 0; i < VSIZE; i++) vmem[i] = 16'($urandom);
        model_reset();
        test_reset();
        test_basic();
        test_no_marker();
        test_swap_read();
        test_ignore();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
